// File: rtl/data_chk_pkg.sv
// Shared types and constants for the eight-channel ramp data checker.
package data_chk_pkg;

   localparam int DATA_W = 12;
   localparam int NUM_CH = 8;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      CH_A = 3'd0,
      CH_B = 3'd1,
      CH_C = 3'd2,
      CH_D = 3'd3,
      CH_E = 3'd4,
      CH_F = 3'd5,
      CH_G = 3'd6,
      CH_H = 3'd7
   } ch_t;

   // Channels A-D carry base+0..3 and E-H repeat the same pattern.
   function automatic logic [DATA_W-1:0] ch_offset(input int ch);
      return DATA_W'(ch % 4);
   endfunction

endpackage

// File: rtl/data_chk_lane.sv
// Per-channel compare: flags a received value that differs from base+OFFSET (mod 2^DATA_W).
module data_chk_lane
   import data_chk_pkg::*;
#(
   parameter logic [DATA_W-1:0] OFFSET = '0
) (
   input  logic [DATA_W-1:0] rx_val,
   input  logic [DATA_W-1:0] base_val,
   output logic              mismatch
);

   logic [DATA_W-1:0] expected_val;

   assign expected_val = base_val + OFFSET;
   assign mismatch     = (rx_val != expected_val);

endmodule

// File: rtl/data_chk_submodule.sv
// Ramp data checker: spatial/temporal sample check, SEARCH/LOCKED acquisition, error and wrap counters.
// Define DATA_CHK_FIRST_ERR_EN to add first-error capture (first_err_ch / first_err_val).
module data_chk_submodule
   import data_chk_pkg::*;
#(
   parameter int RAMP_MAX = 511,
   parameter int LOCK_CNT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] Data_A,
   input  logic [DATA_W-1:0] Data_B,
   input  logic [DATA_W-1:0] Data_C,
   input  logic [DATA_W-1:0] Data_D,
   input  logic [DATA_W-1:0] Data_E,
   input  logic [DATA_W-1:0] Data_F,
   input  logic [DATA_W-1:0] Data_G,
   input  logic [DATA_W-1:0] Data_H,
   input  logic              err_clr,
   output logic              locked,
   output logic              err_flag,
   output logic [15:0]       err_cnt,
   output logic [15:0]       wrap_cnt
`ifdef DATA_CHK_FIRST_ERR_EN
   , output logic [2:0]      first_err_ch,
   output logic [DATA_W-1:0] first_err_val
`endif
);

   localparam int                RUN_W      = $clog2(LOCK_CNT + 1);
   localparam logic [DATA_W-1:0] RAMP_MAX_V = DATA_W'(RAMP_MAX);

   logic [DATA_W-1:0] ch_data [NUM_CH];
   logic [NUM_CH-1:0] lane_mismatch;

   assign ch_data[0] = Data_A;
   assign ch_data[1] = Data_B;
   assign ch_data[2] = Data_C;
   assign ch_data[3] = Data_D;
   assign ch_data[4] = Data_E;
   assign ch_data[5] = Data_F;
   assign ch_data[6] = Data_G;
   assign ch_data[7] = Data_H;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
         data_chk_lane #(
            .OFFSET (ch_offset(gi))
         ) u_lane (
            .rx_val   (ch_data[gi]),
            .base_val (Data_A),
            .mismatch (lane_mismatch[gi])
         );
      end
   endgenerate

   state_t            state_reg, state_next;
   logic [RUN_W-1:0]  good_run_reg, good_run_next;
   logic [DATA_W-1:0] prev_a_reg;
   logic              prev_valid_reg;
   logic              locked_reg, err_flag_reg, err_flag_next;
   logic [15:0]       err_cnt_reg, err_cnt_next;
   logic [15:0]       wrap_cnt_reg, wrap_cnt_next;

   logic [DATA_W-1:0] temporal_expected;
   logic              temporal_good, sample_good, is_wrap;
   logic              count_err, count_wrap;

   assign temporal_expected = (prev_a_reg == RAMP_MAX_V) ? '0 : prev_a_reg + 1'b1;
   // Out-of-range A is bad even on the very first sample after reset.
   assign temporal_good = (Data_A <= RAMP_MAX_V) &&
                          (!prev_valid_reg || (Data_A == temporal_expected));
   assign sample_good   = !(|lane_mismatch) && temporal_good;
   assign is_wrap       = prev_valid_reg && (prev_a_reg == RAMP_MAX_V) && (Data_A == '0);

   always_comb begin
      state_next    = state_reg;
      good_run_next = good_run_reg;
      count_err     = 1'b0;
      count_wrap    = 1'b0;
      case (state_reg)
         SEARCH: begin
            if (!sample_good) begin
               good_run_next = '0;
            end else if (good_run_reg == RUN_W'(LOCK_CNT - 1)) begin
               state_next    = LOCKED;
               good_run_next = '0;
            end else begin
               good_run_next = good_run_reg + 1'b1;
            end
         end
         LOCKED: begin
            if (!sample_good) begin
               state_next    = SEARCH;
               good_run_next = '0;
               count_err     = 1'b1;
            end else begin
               count_wrap = is_wrap;
            end
         end
         default: begin
            state_next    = SEARCH;
            good_run_next = '0;
         end
      endcase
   end

   always_comb begin
      err_cnt_next  = err_cnt_reg;
      err_flag_next = err_flag_reg;
      wrap_cnt_next = wrap_cnt_reg + {15'd0, count_wrap};
      if (err_clr) begin
         err_cnt_next  = '0;
         err_flag_next = 1'b0;
      end else if (count_err) begin
         err_flag_next = 1'b1;
         if (err_cnt_reg != 16'hFFFF) begin
            err_cnt_next = err_cnt_reg + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= SEARCH;
         good_run_reg   <= '0;
         prev_a_reg     <= '0;
         prev_valid_reg <= 1'b0;
         locked_reg     <= 1'b0;
         err_flag_reg   <= 1'b0;
         err_cnt_reg    <= '0;
         wrap_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         good_run_reg   <= good_run_next;
         prev_a_reg     <= Data_A;
         prev_valid_reg <= 1'b1;
         locked_reg     <= (state_next == LOCKED);
         err_flag_reg   <= err_flag_next;
         err_cnt_reg    <= err_cnt_next;
         wrap_cnt_reg   <= wrap_cnt_next;
      end
   end

   assign locked   = locked_reg;
   assign err_flag = err_flag_reg;
   assign err_cnt  = err_cnt_reg;
   assign wrap_cnt = wrap_cnt_reg;

`ifdef DATA_CHK_FIRST_ERR_EN
   ch_t               first_ch_sel;
   logic [2:0]        first_err_ch_reg;
   logic [DATA_W-1:0] first_err_val_reg;

   // Lowest failing lane wins; a purely temporal failure reports channel A.
   always_comb begin
      first_ch_sel = CH_A;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (lane_mismatch[i]) begin
            first_ch_sel = ch_t'(i[2:0]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_err_ch_reg  <= '0;
         first_err_val_reg <= '0;
      end else if (err_clr) begin
         first_err_ch_reg  <= '0;
         first_err_val_reg <= '0;
      end else if (count_err && !err_flag_reg) begin
         first_err_ch_reg  <= first_ch_sel;
         first_err_val_reg <= ch_data[first_ch_sel];
      end
   end

   assign first_err_ch  = first_err_ch_reg;
   assign first_err_val = first_err_val_reg;
`endif

endmodule

// File: tb/tb_data_chk_submodule.sv
// Directed self-checking bench for data_chk_submodule (default parameters).
module tb_data_chk_submodule;

   logic        clk;
   logic        reset_n;
   logic [11:0] Data_A, Data_B, Data_C, Data_D, Data_E, Data_F, Data_G, Data_H;
   logic        err_clr;
   logic        locked;
   logic        err_flag;
   logic [15:0] err_cnt;
   logic [15:0] wrap_cnt;
`ifdef DATA_CHK_FIRST_ERR_EN
   logic [2:0]  first_err_ch;
   logic [11:0] first_err_val;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   data_chk_submodule dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .Data_A   (Data_A),
      .Data_B   (Data_B),
      .Data_C   (Data_C),
      .Data_D   (Data_D),
      .Data_E   (Data_E),
      .Data_F   (Data_F),
      .Data_G   (Data_G),
      .Data_H   (Data_H),
      .err_clr  (err_clr),
      .locked   (locked),
      .err_flag (err_flag),
      .err_cnt  (err_cnt),
      .wrap_cnt (wrap_cnt)
`ifdef DATA_CHK_FIRST_ERR_EN
      , .first_err_ch  (first_err_ch),
      .first_err_val (first_err_val)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic chk_first(input string tag, input logic [2:0] ch, input logic [11:0] val);
`ifdef DATA_CHK_FIRST_ERR_EN
      chk({tag, "_ch"}, 32'(first_err_ch), 32'(ch));
      chk({tag, "_val"}, 32'(first_err_val), 32'(val));
`endif
   endtask

   // Apply one sample just after a rising edge; return 1 time unit after the edge that samples it.
   task automatic step_raw(input logic [11:0] a, b, c, d, e, f, g, h);
      Data_A = a; Data_B = b; Data_C = c; Data_D = d;
      Data_E = e; Data_F = f; Data_G = g; Data_H = h;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [11:0] a);
      step_raw(a, a + 12'd1, a + 12'd2, a + 12'd3, a, a + 12'd1, a + 12'd2, a + 12'd3);
   endtask

   initial begin
      reset_n = 1'b0;
      err_clr = 1'b0;
      Data_A = '0; Data_B = '0; Data_C = '0; Data_D = '0;
      Data_E = '0; Data_F = '0; Data_G = '0; Data_H = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_flag", 32'(err_flag), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
      chk_first("rst_first", 3'd0, 12'd0);
      reset_n = 1'b1;

      // Ramp acquisition: lock one clk after the 4th good sample
      step(12'd0); step(12'd1); step(12'd2);
      chk("acq_locked_3", 32'(locked), 32'd0);
      step(12'd3);
      chk("acq_locked_4", 32'(locked), 32'd1);
      chk("acq_err_cnt", 32'(err_cnt), 32'd0);
      for (int a = 4; a <= 511; a++) step(12'(a));
      chk("ramp_wrap_before", 32'(wrap_cnt), 32'd0);
      step(12'd0);
      chk("ramp_wrap_after", 32'(wrap_cnt), 32'd1);
      chk("ramp_locked", 32'(locked), 32'd1);
      chk("ramp_err_cnt", 32'(err_cnt), 32'd0);

      // Channel C wrong at A=100
      for (int a = 1; a <= 99; a++) step(12'(a));
      step_raw(12'd100, 12'd101, 12'd101, 12'd103, 12'd100, 12'd101, 12'd102, 12'd103);
      chk("chC_err_flag", 32'(err_flag), 32'd1);
      chk("chC_err_cnt", 32'(err_cnt), 32'd1);
      chk("chC_locked", 32'(locked), 32'd0);
      chk_first("chC_first", 3'd2, 12'd101);
      step(12'd101); step(12'd102); step(12'd103);
      chk("chC_relock_3", 32'(locked), 32'd0);
      step(12'd104);
      chk("chC_relock_4", 32'(locked), 32'd1);

      // err_clr while locked leaves the FSM alone
      err_clr = 1'b1;
      step(12'd105);
      err_clr = 1'b0;
      chk("clr_err_flag", 32'(err_flag), 32'd0);
      chk("clr_err_cnt", 32'(err_cnt), 32'd0);
      chk("clr_locked", 32'(locked), 32'd1);
      chk_first("clr_first", 3'd0, 12'd0);

      // Temporal-only failure: A jumps 200 -> 205
      for (int a = 106; a <= 200; a++) step(12'(a));
      step(12'd205);
      chk("jump_err_cnt", 32'(err_cnt), 32'd1);
      chk("jump_locked", 32'(locked), 32'd0);
      chk_first("jump_first", 3'd0, 12'd205);

      // Mismatches in SEARCH are not counted
      err_clr = 1'b1;
      step(12'd206);
      err_clr = 1'b0;
      chk("search_clr_cnt", 32'(err_cnt), 32'd0);
      step(12'd300);
      chk("search_err_cnt", 32'(err_cnt), 32'd0);
      chk("search_err_flag", 32'(err_flag), 32'd0);
      step(12'd301); step(12'd302); step(12'd303);
      chk("search_relock_3", 32'(locked), 32'd0);
      step(12'd304);
      chk("search_relock_4", 32'(locked), 32'd1);
      for (int a = 305; a <= 511; a++) step(12'(a));
      step(12'd0);
      chk("wrap2_cnt", 32'(wrap_cnt), 32'd2);

      // Saturation of err_cnt, then err_clr beating a simultaneous error
      force dut.err_cnt_reg = 16'hFFFF;
      step(12'd1);
      release dut.err_cnt_reg;
      chk("sat_preload", 32'(err_cnt), 32'hFFFF);
      step_raw(12'd2, 12'd3, 12'd4, 12'd5, 12'd2, 12'd3, 12'd4, 12'd2);
      chk("sat_err_cnt", 32'(err_cnt), 32'hFFFF);
      chk("sat_err_flag", 32'(err_flag), 32'd1);
      chk("sat_locked", 32'(locked), 32'd0);
      chk_first("sat_first", 3'd7, 12'd2);
      step(12'd3); step(12'd4); step(12'd5); step(12'd6);
      chk("sat_relock", 32'(locked), 32'd1);
      err_clr = 1'b1;
      step_raw(12'd7, 12'd8, 12'd9, 12'd7, 12'd7, 12'd8, 12'd9, 12'd10);
      err_clr = 1'b0;
      chk("clrpri_err_cnt", 32'(err_cnt), 32'd0);
      chk("clrpri_err_flag", 32'(err_flag), 32'd0);
      chk("clrpri_locked", 32'(locked), 32'd0);
      chk_first("clrpri_first", 3'd0, 12'd0);

      // Reset pulsed mid-LOCKED with non-zero counters
      step(12'd8); step(12'd9); step(12'd10); step(12'd11);
      chk("pre_rst_lock1", 32'(locked), 32'd1);
      step_raw(12'd12, 12'd12, 12'd14, 12'd15, 12'd12, 12'd13, 12'd14, 12'd15);
      chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
      chk_first("pre_rst_first", 3'd1, 12'd12);
      step(12'd13); step(12'd14); step(12'd15); step(12'd16);
      chk("pre_rst_lock2", 32'(locked), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_locked", 32'(locked), 32'd0);
      chk("arst_err_flag", 32'(err_flag), 32'd0);
      chk("arst_err_cnt", 32'(err_cnt), 32'd0);
      chk("arst_wrap_cnt", 32'(wrap_cnt), 32'd0);
      chk_first("arst_first", 3'd0, 12'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Out-of-range A is bad even with correct offsets and a consistent step
      step(12'd600); step(12'd601); step(12'd602); step(12'd603);
      chk("range_locked", 32'(locked), 32'd0);
      chk("range_err_cnt", 32'(err_cnt), 32'd0);
      step(12'd0); step(12'd1); step(12'd2); step(12'd3);
      chk("reacq_locked_3", 32'(locked), 32'd0);
      step(12'd4);
      chk("reacq_locked_4", 32'(locked), 32'd1);
      chk("reacq_err_cnt", 32'(err_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
